// File: rtl/clk_rst_pkg.sv
// Shared clock/reset definitions used by clock_manager and the reset sequencer.
// State encoding, default bring-up timing and the per-state output map.
package clk_rst_pkg;

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_REL_NTSC  = 3'd2;
  localparam logic [2:0] S_REL_USB   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  typedef enum logic [2:0] {
    PLL_RST   = S_PLL_RST,
    WAIT_LOCK = S_WAIT_LOCK,
    REL_NTSC  = S_REL_NTSC,
    REL_USB   = S_REL_USB,
    RUN       = S_RUN,
    FAULT     = S_FAULT
  } state_t;

  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 270000;
  localparam int DEF_STAGE_DELAY         = 64;
  localparam int DEF_MAX_RETRIES         = 3;

  typedef struct packed {
    logic pll_reset;
    logic rst_ntsc_n;
    logic rst_usb_n;
    logic sys_ready;
    logic fault;
  } outs_t;

  // Output levels are a pure function of the state being entered.
  function automatic outs_t outs_of(state_t s);
    outs_t o;
    o.pll_reset  = (s == PLL_RST) || (s == FAULT);
    o.rst_ntsc_n = (s == REL_NTSC) || (s == REL_USB)
                || (s == RUN);
    o.rst_usb_n  = (s == REL_USB) || (s == RUN);
    o.sys_ready  = (s == RUN);
    o.fault      = (s == FAULT);
    return o;
  endfunction

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL supervision and domain-reset bundle.
// master = the sequencer, slave = PLL wrapper and reset consumers.
interface pll_reset_sequencer_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  logic          pll_locked;
  logic          sw_reset_req;
  logic          pll_reset;
  logic          rst_ntsc_n;
  logic          rst_usb_n;
  logic          sys_ready;
  logic          lock_lost;
  logic          fault;
  logic [RW-1:0] retry_cnt;

  modport master (
    input  pll_locked, sw_reset_req,
    output pll_reset, rst_ntsc_n, rst_usb_n,
    output sys_ready, lock_lost, fault, retry_cnt
  );

  modport slave (
    output pll_locked, sw_reset_req,
    input  pll_reset, rst_ntsc_n, rst_usb_n,
    input  sys_ready, lock_lost, fault, retry_cnt
  );
endinterface

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous level signals.
// Resets to 0 so an unknown input reads as deasserted.
module sync_2ff (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse, debounced lock wait, ordered NTSC/USB reset release.
// Lock loss after release restarts the whole sequence.
module pll_reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int STAGE_DELAY         = DEF_STAGE_DELAY,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  pll_reset_sequencer_if.master bus
);
  localparam int CMAX = max_int(
    max_int(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
    max_int(LOCK_TIMEOUT_CYCLES, STAGE_DELAY));
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int RW = $clog2(MAX_RETRIES + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [RW-1:0] rty_t;

  localparam cnt_t PR_LAST = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t LS_LAST = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam cnt_t TO_LAST = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
  localparam cnt_t SD_LAST = cnt_t'(STAGE_DELAY - 1);
  localparam rty_t RTY_MAX = rty_t'(MAX_RETRIES);

  state_t state;
  outs_t  outs;
  cnt_t   cnt;
  cnt_t   stab;
  rty_t   retry;
  logic   lost;
  logic   lock_s;
  logic   drop;

  function automatic cnt_t sat_inc(cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

  sync_2ff u_lock_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (bus.pll_locked),
    .q      (lock_s)
  );

  assign drop = !lock_s
             && (state == REL_NTSC
              || state == REL_USB
              || state == RUN);

  // cnt is the per-state cycle counter (timeout in WAIT_LOCK),
  // stab the consecutive-lock counter.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= PLL_RST;
      outs  <= outs_of(PLL_RST);
      cnt   <= '0;
      stab  <= '0;
      retry <= '0;
      lost  <= 1'b0;
    end else if (bus.sw_reset_req || drop) begin
      state <= PLL_RST;
      outs  <= outs_of(PLL_RST);
      cnt   <= '0;
      stab  <= '0;
      if (bus.sw_reset_req) retry <= '0;
      else                  lost  <= 1'b1;
    end else begin
      unique case (state)
        PLL_RST: begin
          if (cnt == PR_LAST) begin
            state <= WAIT_LOCK;
            outs  <= outs_of(WAIT_LOCK);
            cnt   <= '0;
            stab  <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        WAIT_LOCK: begin
          if (cnt == TO_LAST) begin
            cnt  <= '0;
            stab <= '0;
            if (retry < RTY_MAX) begin
              retry <= retry + rty_t'(1);
              state <= PLL_RST;
              outs  <= outs_of(PLL_RST);
            end else begin
              state <= FAULT;
              outs  <= outs_of(FAULT);
            end
          end else if (lock_s && stab == LS_LAST) begin
            state <= REL_NTSC;
            outs  <= outs_of(REL_NTSC);
            cnt   <= '0;
            stab  <= '0;
          end else begin
            cnt  <= sat_inc(cnt);
            stab <= lock_s ? sat_inc(stab) : '0;
          end
        end
        REL_NTSC: begin
          if (cnt == SD_LAST) begin
            state <= REL_USB;
            outs  <= outs_of(REL_USB);
            cnt   <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        REL_USB: begin
          if (cnt == SD_LAST) begin
            state <= RUN;
            outs  <= outs_of(RUN);
            cnt   <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        RUN, FAULT: begin
        end
        default: begin
          state <= PLL_RST;
          outs  <= outs_of(PLL_RST);
          cnt   <= '0;
          stab  <= '0;
        end
      endcase
    end
  end

  assign bus.pll_reset  = outs.pll_reset;
  assign bus.rst_ntsc_n = outs.rst_ntsc_n;
  assign bus.rst_usb_n  = outs.rst_usb_n;
  assign bus.sys_ready  = outs.sys_ready;
  assign bus.fault      = outs.fault;
  assign bus.lock_lost  = lost;
  assign bus.retry_cnt  = retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: random lock waveforms against an
// event-time model derived from the bring-up rules.
module tb_pll_reset_sequencer;
  localparam int P    = 4;
  localparam int ST   = 8;
  localparam int TO   = 100;
  localparam int SD   = 5;
  localparam int MR   = 2;
  localparam int MAXC = 600;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // raw[k]/sw[k]: input levels seen by clock edge k after rst_n release
  bit   raw [0:MAXC];
  bit   sw  [0:MAXC];
  logic o_pr [0:MAXC];
  logic o_nt [0:MAXC];
  logic o_us [0:MAXC];
  logic o_rd [0:MAXC];
  logic o_ll [0:MAXC];
  logic o_ft [0:MAXC];
  logic [1:0] o_rc [0:MAXC];

  pll_reset_sequencer_if #(.MAX_RETRIES(MR)) bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (P),
    .LOCK_STABLE_CYCLES  (ST),
    .LOCK_TIMEOUT_CYCLES (TO),
    .STAGE_DELAY         (SD),
    .MAX_RETRIES         (MR)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus.master)
  );

  always #5 clk_in = ~clk_in;

  task automatic sample();
    o_pr[cyc] = bus.pll_reset;
    o_nt[cyc] = bus.rst_ntsc_n;
    o_us[cyc] = bus.rst_usb_n;
    o_rd[cyc] = bus.sys_ready;
    o_ll[cyc] = bus.lock_lost;
    o_ft[cyc] = bus.fault;
    o_rc[cyc] = bus.retry_cnt;
  endtask

  task automatic fill(bit v);
    for (int i = 0; i <= MAXC; i++) begin
      raw[i] = v;
      sw[i]  = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n = 1'b0;
    bus.sw_reset_req = 1'b0;
    repeat (2) @(negedge clk_in);
    bus.pll_locked = raw[1];
    rst_n = 1'b1;
    cyc = 0;
    sample();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      if (cyc >= MAXC) break;
      bus.pll_locked   = raw[cyc+1];
      bus.sw_reset_req = sw[cyc+1];
      @(negedge clk_in);
      cyc++;
      sample();
    end
    bus.sw_reset_req = 1'b0;
  endtask

  function automatic int first(int sel, logic v, int from);
    for (int k = from; k <= cyc; k++) begin
      logic b;
      case (sel)
        0: b = o_pr[k];
        1: b = o_nt[k];
        2: b = o_us[k];
        3: b = o_rd[k];
        default: b = o_ft[k];
      endcase
      if (b === v) return k;
    end
    return -1;
  endfunction

  // Lock is seen two edges late; release needs ST consecutive seen-high
  // edges inside the WAIT_LOCK window starting after edge w.
  function automatic int exp_release(int w);
    int run_len = 0;
    for (int k = w + 1; k < w + TO; k++) begin
      if (k - 2 >= 1 && raw[k-2]) run_len++;
      else run_len = 0;
      if (run_len == ST) return k;
    end
    return -1;
  endfunction

  task automatic test_reset();
    logic [7:0] got;
    bus.pll_locked = 1'b0;
    bus.sw_reset_req = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    got = {bus.pll_reset, bus.rst_ntsc_n, bus.rst_usb_n,
           bus.sys_ready, bus.lock_lost, bus.fault,
           bus.retry_cnt};
    checks++;
    if (got !== 8'h80) begin
      failures++;
      $display("FAIL por_values got=%b exp=%b", got, 8'h80);
    end
  endtask

  task automatic test_clean_start();
    int t_pr, t_nt, t_us, t_rd, e;
    fill(1'b1);
    do_reset();
    run(40);
    t_pr = first(0, 1'b0, 0);
    t_nt = first(1, 1'b1, 0);
    t_us = first(2, 1'b1, 0);
    t_rd = first(3, 1'b1, 0);
    e = exp_release(P);
    checks++;
    if (t_pr !== P) begin
      failures++;
      $display("FAIL clean_pr_fall got=%0d exp=%0d", t_pr, P);
    end
    checks++;
    if (t_nt !== e) begin
      failures++;
      $display("FAIL clean_ntsc got=%0d exp=%0d", t_nt, e);
    end
    checks++;
    if (t_nt < P + ST || t_nt > P + ST + 2) begin
      failures++;
      $display("FAIL clean_ntsc_win got=%0d exp=%0d..%0d",
               t_nt, P + ST, P + ST + 2);
    end
    checks++;
    if (t_us !== t_nt + SD) begin
      failures++;
      $display("FAIL clean_usb got=%0d exp=%0d", t_us, t_nt + SD);
    end
    checks++;
    if (t_rd !== t_us + SD) begin
      failures++;
      $display("FAIL clean_ready got=%0d exp=%0d", t_rd, t_us + SD);
    end
    checks++;
    if (o_rc[cyc] !== 2'd0 || o_ll[cyc] !== 1'b0) begin
      failures++;
      $display("FAIL clean_flags got=%0d/%0d exp=0/0",
               o_rc[cyc], o_ll[cyc]);
    end
  endtask

  task automatic test_lock_glitch();
    int g, e, t_nt, t_rd;
    fill(1'b1);
    g = int'($urandom_range(5, 11));
    raw[g] = 1'b0;
    if ($urandom_range(0, 1) == 1)
      raw[g + int'($urandom_range(3, 9))] = 1'b0;
    do_reset();
    run(70);
    e = exp_release(P);
    t_nt = first(1, 1'b1, 0);
    t_rd = first(3, 1'b1, 0);
    checks++;
    if (t_nt !== e) begin
      failures++;
      $display("FAIL glitch_ntsc g=%0d got=%0d exp=%0d", g, t_nt, e);
    end
    checks++;
    if (t_rd !== e + 2 * SD) begin
      failures++;
      $display("FAIL glitch_ready got=%0d exp=%0d", t_rd, e + 2 * SD);
    end
    checks++;
    if (first(0, 1'b1, P + 1) !== -1 || o_rc[cyc] !== 2'd0) begin
      failures++;
      $display("FAIL glitch_no_retry got=%0d exp=0", o_rc[cyc]);
    end
  endtask

  task automatic test_lock_loss_run();
    int d, l, w, e, t_nt, t_rd, s;
    fill(1'b1);
    d = int'($urandom_range(30, 60));
    l = int'($urandom_range(2, 20));
    for (int i = d; i < d + l; i++) raw[i] = 1'b0;
    do_reset();
    run(d + 60);
    checks++;
    if (o_rd[d+1] !== 1'b1 || o_ll[d+1] !== 1'b0) begin
      failures++;
      $display("FAIL loss_pre got=%0d/%0d exp=1/0",
               o_rd[d+1], o_ll[d+1]);
    end
    checks++;
    if ({o_nt[d+2], o_us[d+2], o_rd[d+2], o_ll[d+2], o_pr[d+2]}
        !== 5'b00011) begin
      failures++;
      $display("FAIL loss_react got=%b exp=%b",
               {o_nt[d+2], o_us[d+2], o_rd[d+2], o_ll[d+2], o_pr[d+2]},
               5'b00011);
    end
    w = d + 2 + P;
    e = exp_release(w);
    t_nt = first(1, 1'b1, d + 2);
    t_rd = first(3, 1'b1, d + 2);
    checks++;
    if (first(0, 1'b0, d + 2) !== w) begin
      failures++;
      $display("FAIL loss_pr_fall got=%0d exp=%0d",
               first(0, 1'b0, d + 2), w);
    end
    checks++;
    if (t_nt !== e || t_rd !== e + 2 * SD) begin
      failures++;
      $display("FAIL loss_reseq got=%0d,%0d exp=%0d,%0d",
               t_nt, t_rd, e, e + 2 * SD);
    end
    checks++;
    if (o_ll[cyc] !== 1'b1 || o_rc[cyc] !== 2'd0) begin
      failures++;
      $display("FAIL loss_flags got=%0d/%0d exp=1/0",
               o_ll[cyc], o_rc[cyc]);
    end
    s = cyc + 2;
    sw[s] = 1'b1;
    run(5);
    checks++;
    if ({o_rd[s-1], o_rd[s], o_pr[s], o_ll[s]} !== 4'b1011) begin
      failures++;
      $display("FAIL loss_sw_keeps_lost got=%b exp=%b",
               {o_rd[s-1], o_rd[s], o_pr[s], o_ll[s]}, 4'b1011);
    end
  endtask

  task automatic test_timeout_fault();
    int f, c;
    fill(1'b0);
    for (int i = 1; i <= MAXC; i++)
      raw[i] = (i % 7 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    do_reset();
    run(3 * (P + TO) + 20);
    checks++;
    if (first(0, 1'b0, 0) !== P) begin
      failures++;
      $display("FAIL to_pr_fall got=%0d exp=%0d", first(0, 1'b0, 0), P);
    end
    for (int a = 1; a <= MR; a++) begin
      c = a * (P + TO);
      checks++;
      if (o_rc[c-1] !== 2'(a - 1) || o_rc[c] !== 2'(a)) begin
        failures++;
        $display("FAIL to_retry a=%0d got=%0d->%0d exp=%0d->%0d",
                 a, o_rc[c-1], o_rc[c], a - 1, a);
      end
      checks++;
      if ({o_pr[c-1], o_pr[c], o_pr[c+P-1], o_pr[c+P]} !== 4'b0110) begin
        failures++;
        $display("FAIL to_pulse a=%0d got=%b exp=%b", a,
                 {o_pr[c-1], o_pr[c], o_pr[c+P-1], o_pr[c+P]}, 4'b0110);
      end
    end
    f = (MR + 1) * (P + TO);
    checks++;
    if ({o_ft[f-1], o_ft[f], o_pr[f], o_ft[cyc], o_pr[cyc]} !== 5'b01111
        || o_rc[cyc] !== 2'(MR)) begin
      failures++;
      $display("FAIL to_fault got=%b rc=%0d exp=%b rc=%0d",
               {o_ft[f-1], o_ft[f], o_pr[f], o_ft[cyc], o_pr[cyc]},
               o_rc[cyc], 5'b01111, MR);
    end
    checks++;
    if (first(1, 1'b1, 0) !== -1) begin
      failures++;
      $display("FAIL to_no_release got=%0d exp=-1", first(1, 1'b1, 0));
    end
  endtask

  task automatic test_fault_recovery();
    int s, e, t_nt, t_rd;
    for (int i = cyc + 1; i <= MAXC; i++) raw[i] = 1'b1;
    s = cyc + int'($urandom_range(3, 10));
    sw[s] = 1'b1;
    run(s - cyc + 40);
    checks++;
    if ({o_ft[s-1], o_ft[s], o_pr[s]} !== 3'b101 || o_rc[s] !== 2'd0) begin
      failures++;
      $display("FAIL rec_clear got=%b rc=%0d exp=%b rc=0",
               {o_ft[s-1], o_ft[s], o_pr[s]}, o_rc[s], 3'b101);
    end
    e = exp_release(s + P);
    t_nt = first(1, 1'b1, s);
    t_rd = first(3, 1'b1, s);
    checks++;
    if (first(0, 1'b0, s) !== s + P || t_nt !== e) begin
      failures++;
      $display("FAIL rec_seq got=%0d,%0d exp=%0d,%0d",
               first(0, 1'b0, s), t_nt, s + P, e);
    end
    checks++;
    if (t_rd !== e + 2 * SD || o_ll[cyc] !== 1'b0) begin
      failures++;
      $display("FAIL rec_ready got=%0d exp=%0d", t_rd, e + 2 * SD);
    end
  endtask

  task automatic test_async_reset();
    int m;
    logic [7:0] got;
    fill(1'b1);
    do_reset();
    m = int'($urandom_range(P + ST + SD, P + ST + 2 * SD - 1));
    run(m);
    checks++;
    if (o_us[m] !== 1'b1 || o_rd[m] !== 1'b0) begin
      failures++;
      $display("FAIL ar_in_rel_usb got=%0d/%0d exp=1/0", o_us[m], o_rd[m]);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {bus.pll_reset, bus.rst_ntsc_n, bus.rst_usb_n,
           bus.sys_ready, bus.lock_lost, bus.fault,
           bus.retry_cnt};
    checks++;
    if (got !== 8'h80) begin
      failures++;
      $display("FAIL ar_values got=%b exp=%b", got, 8'h80);
    end
    do_reset();
    run(P + 2);
    checks++;
    if (first(0, 1'b0, 0) !== P) begin
      failures++;
      $display("FAIL ar_restart got=%0d exp=%0d", first(0, 1'b0, 0), P);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_start();
    test_lock_glitch();
    test_lock_loss_run();
    test_timeout_fault();
    test_fault_recovery();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Supervises the PLL inside `clock_manager` and sequences the domain resets derived from it. It pulses the PLL reset and waits for a debounced, stable lock, then releases the NTSC reset and the USB reset in order. Lock loss is treated as a fatal clock event that re-runs the whole sequence. The block runs on the free-running 27 MHz board clock. It sits between the top-level reset pin and every clocked subsystem.

## Interface
- `PLL_RST_CYCLES`, 16: cycles `pll_reset` is held high per attempt.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synced-lock cycles required.
- `LOCK_TIMEOUT_CYCLES`, 270000: cycles allowed in WAIT_LOCK per attempt (10 ms).
- `STAGE_DELAY`, 64: cycles between successive reset releases.
- `MAX_RETRIES`, 3: failed attempts tolerated before FAULT.

Ports:
- `clk_in` in 1: 27 MHz free-running clock, the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: raw PLL lock, asynchronous to `clk_in`.
- `sw_reset_req` in 1: synchronous single-cycle restart request.
- `pll_reset` out 1: active-high reset to the PLL.
- `rst_ntsc_n` out 1: active-low reset for the NTSC domain.
- `rst_usb_n` out 1: active-low reset for the USB domain.
- `sys_ready` out 1: high only in RUN.
- `lock_lost` out 1: sticky flag, set on any lock drop in REL_NTSC, REL_USB or RUN.
- `fault` out 1: high in FAULT.
- `retry_cnt` out `$clog2(MAX_RETRIES+1)`: failed attempts since the last clean start.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `lock_s`. The block never uses the raw signal.
- States:
  - **PLL_RST**: `pll_reset`=1 and both domain resets asserted. After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK.
  - **WAIT_LOCK**: `pll_reset`=0.
    - The stable counter increments while `lock_s`=1 and clears when `lock_s`=0.
    - When the stable count reaches `LOCK_STABLE_CYCLES`, go to REL_NTSC.
    - The timeout counter counts every cycle in this state and is not cleared by lock glitches.
    - On timeout with `retry_cnt` < `MAX_RETRIES`: increment `retry_cnt` and go to PLL_RST.
    - On timeout otherwise: go to FAULT.
  - **REL_NTSC**: `rst_ntsc_n`=1. After `STAGE_DELAY` cycles, go to REL_USB.
  - **REL_USB**: `rst_usb_n`=1. After `STAGE_DELAY` cycles, go to RUN.
  - **RUN**: `sys_ready`=1. Stays here indefinitely.
  - **FAULT**: `pll_reset`=1, all resets asserted, `fault`=1. Only `sw_reset_req` or `rst_n` exits this state.
- Lock drop: `lock_s`=0 in REL_NTSC, REL_USB or RUN causes all of the following on the next edge:
  - `rst_ntsc_n`=0, `rst_usb_n`=0, `sys_ready`=0.
  - `lock_lost` is set.
  - The state moves to PLL_RST.
  - `retry_cnt` is unchanged. A lock drop is not a timeout.
- `sw_reset_req` in any state:
  - Go to PLL_RST and clear `retry_cnt` and `fault`.
  - `lock_lost` is not cleared. Only `rst_n` clears it.
- Priority within a cycle: `sw_reset_req` > lock drop > timeout > normal stage advance.
- Counters:
  - All counters are `$clog2` of the largest cycle parameter wide.
  - They clear on every state entry.
  - They saturate and never wrap.

## Timing
- Reset value of every output: `pll_reset`=1, `rst_ntsc_n`=0, `rst_usb_n`=0, `sys_ready`=0, `lock_lost`=0, `fault`=0, `retry_cnt`=0. The state resets to PLL_RST.
- All outputs are registered and change only on a `clk_in` rising edge. The exception is `rst_n` assertion, which forces reset values asynchronously.
- `rst_n` asserted mid-sequence returns every output to reset values immediately.
- Synchronizer latency: a `pll_locked` edge reaches `lock_s` after 2 clocks.
- Nominal bring-up with lock already high: `sys_ready` rises PLL_RST_CYCLES + LOCK_STABLE_CYCLES + 2×STAGE_DELAY (±2 synchronizer) cycles after `rst_n` release.
- Release order is guaranteed: `rst_ntsc_n` rises `STAGE_DELAY` cycles before `rst_usb_n`, and `rst_usb_n` rises `STAGE_DELAY` cycles before `sys_ready`.
- Lock-drop reaction: resets are asserted 3 clocks after the raw `pll_locked` falls (2 synchronizer clocks plus 1 registered output).

## Structure
- Shared package `clk_rst_pkg`:
  - state encoding localparams for PLL_RST, WAIT_LOCK, REL_NTSC, REL_USB, RUN and FAULT;
  - default cycle parameters, so `clock_manager` and the top level agree.
- One sub-module, `sync_2ff`: a 1-bit, 2-flop synchronizer with async active-low reset that resets to 0. The team reuses it for other CDC bits.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=100, STAGE_DELAY=5, MAX_RETRIES=2.

- **Clean start**: `pll_locked`=1 throughout, `rst_n` released at t0. Expect:
  - `pll_reset` falls at t0+4;
  - `rst_ntsc_n` rises at t0+12..14;
  - `rst_usb_n` rises 5 later, `sys_ready` rises 5 after that;
  - `retry_cnt`=0.
- **Lock glitch in WAIT_LOCK**: lock toggles low for 1 cycle after 6 high cycles. Expect the stable count to restart and `rst_ntsc_n` to be delayed by 7+ cycles, with no retry.
- **Timeout and fault**: `pll_locked`=0 forever. Expect:
  - `retry_cnt` goes 1, then 2, after each 100-cycle window, with a 4-cycle `pll_reset` pulse each time;
  - the third timeout enters FAULT, with `fault`=1 and `pll_reset`=1 held.
- **Lock loss in RUN**: drop `pll_locked`. Expect:
  - 3 clocks later, both resets=0, `sys_ready`=0, `lock_lost`=1;
  - after lock returns, full re-sequence with `lock_lost` still 1.
- **Recovery from FAULT**: pulse `sw_reset_req` in FAULT with lock=1. Expect `fault`=0 and `retry_cnt`=0 next cycle, then normal bring-up.
- **Async reset mid-sequence**: assert `rst_n` mid-REL_USB. Expect all outputs at reset values before the next clock edge.
